clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_chan.sv | 60 ++++++
 rtl/clk_div_bank.sv | 84 ++++++++
 tb/tb_clk_div_bank.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and cfg_ch width helper for the clock divider bank
package clk_div_pkg;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CW    = 32;
  localparam int DEF_LIMIT = 2500000;

  // Channel-select width; a single-channel bank still gets a 1-bit index.
  function automatic int cfg_ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active limit and registered tick/div outputs
module clk_div_chan import clk_div_pkg::*; #(
  parameter int            CW            = DEF_CW,
  parameter logic [CW-1:0] DEFAULT_LIMIT = CW'(DEF_LIMIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_sync,
  input  logic          i_load,
  input  logic [CW-1:0] i_limit,
  output logic          o_loaded,
  output logic          o_tick,
  output logic          o_div
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lim;
  logic          r_tick;
  logic          r_div;

  logic [CW-1:0] w_last;
  logic          w_wrap;
  logic          w_sync;

  // A limit of 0 behaves as 1: the counter sits at 0 and wraps every cycle.
  assign w_last   = (r_lim == '0) ? '0 : r_lim - CW'(1);
  assign w_sync   = i_sync & i_en;
  assign w_wrap   = i_en & (r_cnt == w_last);
  assign o_loaded = i_load & (w_sync | w_wrap | ~i_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_lim  <= DEFAULT_LIMIT;
      r_tick <= 1'b0;
      r_div  <= 1'b0;
    end else begin
      r_tick <= w_wrap & ~w_sync;
      if (w_sync) begin
        r_cnt <= '0;
        r_div <= 1'b0;
      end else if (w_wrap) begin
        r_cnt <= '0;
        r_div <= ~r_div;
      end else if (i_en) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // New limits only land on a phase boundary, so a half-period is never cut short.
      if (o_loaded) begin
        r_lim <= i_limit;
        r_cnt <= '0;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_div  = r_div;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of NCH clock dividers with a single limit-update slot
// Optional phase-restart input sync_in is present when CLKDIV_SYNC_EN is defined.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int          NCH           = DEF_NCH,
  parameter int          CW            = DEF_CW,
  parameter int unsigned DEFAULT_LIMIT = DEF_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [cfg_ch_w(NCH)-1:0] cfg_ch,
  input  logic [CW-1:0]            cfg_limit,
  output logic                     cfg_err,
`ifdef CLKDIV_SYNC_EN
  input  logic                     sync_in,
`endif
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           div_out
);

  localparam int             CHW   = cfg_ch_w(NCH);
  localparam logic [CHW:0]   NCH_V = (CHW+1)'(NCH);

  logic           r_ready;
  logic           r_err;
  logic [CHW-1:0] r_pch;
  logic [CW-1:0]  r_plim;

  logic [NCH-1:0] w_loaded;
  logic           w_sync;
  logic           w_accept;
  logic           w_bad;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  assign w_accept = cfg_valid & r_ready;
  assign w_bad    = ({1'b0, cfg_ch} >= NCH_V);

  // r_ready doubles as the inverted pending flag of the update slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      r_pch   <= '0;
      r_plim  <= '0;
    end else begin
      r_err <= w_accept & w_bad;
      if (w_accept & ~w_bad) begin
        r_ready <= 1'b0;
        r_pch   <= cfg_ch;
        r_plim  <= cfg_limit;
      end else if (|w_loaded) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CW            (CW),
      .DEFAULT_LIMIT (CW'(DEFAULT_LIMIT))
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_en     (en[g]),
      .i_sync   (w_sync),
      .i_load   (~r_ready & (r_pch == CHW'(g))),
      .i_limit  (r_plim),
      .o_loaded (w_loaded[g]),
      .o_tick   (tick[g]),
      .o_div    (div_out[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank; sync tests need CLKDIV_SYNC_EN
module tb_clk_div_bank;
  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int DLIM = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_limit = '0;
  logic           cfg_err;
  logic           sync_in = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] div_out;

  always #5 clk = ~clk;

  clk_div_bank #(.NCH(NCH), .CW(CW), .DEFAULT_LIMIT(DLIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_limit (cfg_limit),
    .cfg_err   (cfg_err),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .tick      (tick),
    .div_out   (div_out)
  );

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] div;
    logic           ready;
    logic           err;
  } exp_t;

  typedef struct {
    int lim0;
    int lim1;
    int p0;
    int p1;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_t[NCH];
  int last_iv[NCH];

  int             m_cnt[NCH];
  int             m_lim[NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_div;
  logic           m_pend;
  logic           m_err;
  int             m_pch;
  int             m_plim;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_lim[i] = DLIM;
      last_t[i] = -1;
      last_iv[i] = 0;
    end
    m_tick = '0;
    m_div  = '0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_pch  = 0;
    m_plim = 0;
  endtask

  // Reference behaviour for one clock edge using the inputs currently driven.
  task automatic model_step();
    bit loaded, acc, ld, wrap, syn;
    int last;
    exp_t e;
    loaded = 0;
    acc = cfg_valid && !m_pend;
    for (int i = 0; i < NCH; i++) begin
      ld   = m_pend && (m_pch == i);
      last = (m_lim[i] == 0) ? 0 : m_lim[i] - 1;
      syn  = sync_in && en[i];
      wrap = en[i] && (m_cnt[i] == last);
      m_tick[i] = wrap && !syn;
      if (syn) begin
        m_cnt[i] = 0;
        m_div[i] = 1'b0;
      end else if (wrap) begin
        m_cnt[i] = 0;
        m_div[i] = ~m_div[i];
      end else if (en[i]) begin
        m_cnt[i]++;
      end
      if (ld && (syn || wrap || !en[i])) begin
        m_lim[i] = m_plim;
        m_cnt[i] = 0;
        loaded = 1;
      end
    end
    m_err = acc && (int'(cfg_ch) >= NCH);
    if (acc && (int'(cfg_ch) < NCH)) begin
      m_pend = 1'b1;
      m_pch  = int'(cfg_ch);
      m_plim = int'(cfg_limit);
    end else if (loaded) begin
      m_pend = 1'b0;
    end
    e.tick = m_tick;
    e.div = m_div;
    e.ready = !m_pend;
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("tick", 32'(tick), 32'(e.tick));
    chk("div_out", 32'(div_out), 32'(e.div));
    chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
    chk("cfg_err", 32'(cfg_err), 32'(e.err));
    for (int i = 0; i < NCH; i++) begin
      if (tick[i]) begin
        if (last_t[i] >= 0) last_iv[i] = cyc - last_t[i];
        last_t[i] = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    cfg_valid = 1'b0;
    sync_in = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_div", 32'(div_out), 32'(0));
    chk("rst_ready", 32'(cfg_ready), 32'(1));
    chk("rst_err", 32'(cfg_err), 32'(0));
    rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input int lim);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_limit = CW'(lim);
    cycle();
    cfg_valid = 1'b0;
    while (!cfg_ready && n < 100) begin
      cycle();
      n++;
    end
    chk("cfg_load_done", 32'(cfg_ready), 32'(1));
  endtask

  task automatic wait_tick(input int ch);
    int n;
    n = 0;
    while (!tick[ch] && n < 200) begin
      cycle();
      n++;
    end
    chk("wait_tick", 32'(tick[ch]), 32'(1));
  endtask

  vec_t vt[5];

  initial begin
    int n;
    logic exp_d;
    vt[0] = '{3, 5, 3, 5};
    vt[1] = '{0, 2, 1, 2};
    vt[2] = '{1, 4, 1, 4};
    vt[3] = '{7, 2, 7, 2};
    vt[4] = '{2, 1, 2, 1};

    // Defaults after reset: every channel runs at DEFAULT_LIMIT.
    do_reset();
    en = 3'b111;
    repeat (20) cycle();
    for (int i = 0; i < NCH; i++) chk("default_period", 32'(last_iv[i]), 32'(DLIM));

    // Period vectors: configure both channels while disabled, then run.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cfg(0, vt[v].lim0);
      cfg(1, vt[v].lim1);
      en = 3'b011;
      repeat (30) cycle();
      chk("period_ch0", 32'(last_iv[0]), 32'(vt[v].p0));
      chk("period_ch1", 32'(last_iv[1]), 32'(vt[v].p1));
    end

    // Update to L=2 while ch0 sits at count 1 of L=4.
    do_reset();
    cfg(0, 4);
    en = 3'b001;
    wait_tick(0);
    cycle();
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_limit = CW'(2);
    cycle();
    cfg_valid = 1'b0;
    chk("shrink_ready_acc", 32'(cfg_ready), 32'(0));
    chk("shrink_tick_acc", 32'(tick[0]), 32'(0));
    cycle();
    chk("shrink_ready_mid", 32'(cfg_ready), 32'(0));
    chk("shrink_tick_mid", 32'(tick[0]), 32'(0));
    cycle();
    chk("shrink_wrap_at3", 32'(tick[0]), 32'(1));
    chk("shrink_ready_load", 32'(cfg_ready), 32'(1));
    repeat (6) cycle();
    chk("shrink_new_period", 32'(last_iv[0]), 32'(2));

    // Out-of-range channel index is dropped with a one-cycle error pulse.
    do_reset();
    en = 3'b011;
    cfg_valid = 1'b1;
    cfg_ch = 2'd3;
    cfg_limit = CW'(9);
    cycle();
    cfg_valid = 1'b0;
    chk("bad_ch_err", 32'(cfg_err), 32'(1));
    chk("bad_ch_ready", 32'(cfg_ready), 32'(1));
    cycle();
    chk("bad_ch_err_clr", 32'(cfg_err), 32'(0));
    repeat (12) cycle();
    chk("bad_ch_period0", 32'(last_iv[0]), 32'(DLIM));
    chk("bad_ch_period1", 32'(last_iv[1]), 32'(DLIM));

    // Freeze ch0 at count 2 of L=5 for 10 cycles, then resume.
    do_reset();
    cfg(0, 5);
    en = 3'b001;
    wait_tick(0);
    cycle();
    cycle();
    en = 3'b000;
    exp_d = m_div[0];
    repeat (10) begin
      cycle();
      chk("frozen_tick", 32'(tick[0]), 32'(0));
      chk("frozen_div", 32'(div_out[0]), 32'(exp_d));
    end
    en = 3'b001;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick[0] && n < 20);
    chk("resume_cycles", 32'(n), 32'(3));

`ifdef CLKDIV_SYNC_EN
    // Sync on a wrap cycle suppresses the tick and clears the phase.
    do_reset();
    cfg(0, 3);
    cfg(1, 5);
    en = 3'b011;
    wait_tick(0);
    cycle();
    cycle();
    chk("pre_sync_div0", 32'(div_out[0]), 32'(1));
    sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    chk("sync_tick", 32'(tick), 32'(0));
    chk("sync_div", 32'(div_out), 32'(0));
    repeat (10) cycle();
    chk("sync_period0", 32'(last_iv[0]), 32'(3));
`endif

    // Asynchronous reset mid-period with an update pending.
    do_reset();
    en = 3'b011;
    repeat (5) cycle();
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_limit = CW'(7);
    cycle();
    cfg_valid = 1'b0;
    chk("pend_before_rst", 32'(cfg_ready), 32'(0));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_tick", 32'(tick), 32'(0));
    chk("async_rst_div", 32'(div_out), 32'(0));
    chk("async_rst_ready", 32'(cfg_ready), 32'(1));
    chk("async_rst_err", 32'(cfg_err), 32'(0));
    do_reset();
    en = 3'b011;
    repeat (20) cycle();
    chk("post_rst_period0", 32'(last_iv[0]), 32'(DLIM));
    chk("post_rst_period1", 32'(last_iv[1]), 32'(DLIM));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
